exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//  Parametrised multi-cycle execution unit; next generation of the datapath ALU.
//  Accepts opcode + operands over a valid/ready handshake. Single-cycle ops finish in 1 cycle.
//  Shifts iterate 1 bit/cycle; MUL is iterative shift-add.
//  Result and S/Z/C/V flags are held until the consumer (DR load / flag register) accepts them.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=4)
//  SHW     4   shift-amount width; d ranges 0..2**SHW-1 (shifts >= WIDTH give all-shifted-out result)
//  MUL_EN  1   1: opcode 10 is MUL; 0: opcode 10 behaves as reserved
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  in_valid   in   1      request present
//  in_ready   out  1      unit can accept a request this cycle
//  opcode     in   4      operation, sampled on in_valid&in_ready
//  d          in   SHW    shift amount, sampled with opcode
//  alu_in_a   in   WIDTH  operand A
//  alu_in_b   in   WIDTH  operand B
//  out_valid  out  1      alu_out/flags valid
//  out_ready  in   1      consumer accepts result
//  alu_out    out  WIDTH  result
//  S,Z,C,V    out  1 each sign, zero, carry, signed overflow
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-op): state=IDLE, in_ready=1 after release, out_valid=0,
//   alu_out=0, S=Z=C=V=0, busy=0; any in-flight op is discarded, no output produced.
//  Accept = in_valid & in_ready; operands, opcode, d are captured; later input changes are ignored.
//  in_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back, 1 op/cycle for single-cycle ops.
//  States: IDLE -(accept, single-cycle op, or shift with d==0)-> DONE;
//   IDLE -(accept shift, d!=0)-> SHIFT; IDLE -(accept MUL)-> MUL;
//   SHIFT: 1 bit/cycle; -> DONE after d cycles.
//   MUL: 1 multiplier bit/cycle; -> DONE after WIDTH cycles.
//   DONE: out_valid=1; on out_ready -> IDLE, or on simultaneous accept -> next op's state.
//  Latency accept->out_valid: 1 (single-cycle, shift d=0); d+1 (shift); WIDTH+1 (MUL).
//  While out_valid & !out_ready: alu_out and flags are held stable.
//  Opcodes (results mod 2**WIDTH):
//   0 ADD  A+B          1 SUB  A-B       2 AND    3 OR      4 XOR    5 NOT ~A
//   6 MOVB B            7 SLL  A<<d      8 SRL  A>>d logical        9 SRA  A>>>d arithmetic
//   10 MUL low WIDTH bits of A*B (unsigned)           11 CMP  alu_out=A, flags as SUB
//   12-15 reserved: alu_out=0, S=0,Z=1,C=0,V=0
//  Flags: S=alu_out[WIDTH-1], Z=(alu_out==0) for all ops except CMP (CMP: S,Z from A-B).
//   ADD: C=carry out. SUB/CMP: C=carry out of A+~B+1 (1 = no borrow).
//   ADD/SUB/CMP: V = signed overflow. Logic/MOVB/NOT: C=V=0.
//   Shifts: C=last bit shifted out (0 if d==0), V=0.
//   MUL: C=V=1 iff upper WIDTH bits of full product !=0.
//  Shift by d>=WIDTH: SLL/SRL -> 0, SRA -> all sign bits; still takes d cycles.
//  in_valid while busy and not DONE&out_ready: ignored (not queued).
// TESTING
//  ADD 0x7FFF+0x0001 -> 1 cycle later out_valid, alu_out=0x8000, S=1,Z=0,C=0,V=1
//  SUB 0x0003-0x0005 -> 0xFFFE, S=1,C=0,V=0; CMP same operands -> alu_out=0x0003, same flags
//  SRA 0x8001 d=4 -> out_valid 5 cycles after accept, 0xF800, C=0; SLL d=0 -> 1 cycle, C=0
//  MUL 0x0100*0x0100 -> after 17 cycles alu_out=0x0000, Z=1, C=V=1; 0x0003*0x0005 -> 0x000F
//  Hold out_ready=0 for 3 cycles after ADD -> outputs stable, in_ready=0; then out_ready=1 with new in_valid -> accepted same cycle
//  rst=0 asserted mid-MUL -> out_valid=0, alu_out=0, busy=0 immediately; no result after release

Source files
------------

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - multi-cycle execution unit: single-cycle ALU ops, iterative shifts and shift-add multiply
module exec_unit #(
    parameter int WIDTH  = 16,
    parameter int SHW    = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [SHW-1:0]   d,
    input  logic [WIDTH-1:0] alu_in_a,
    input  logic [WIDTH-1:0] alu_in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             S,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             busy
);
    localparam int CWA = $clog2(WIDTH + 1);
    localparam int CW  = (SHW > CWA) ? SHW : CWA;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1, OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT  = 4'd5, OP_MOVB = 4'd6, OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA  = 4'd9, OP_MUL = 4'd10, OP_CMP = 4'd11;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               s_q, s_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic [WIDTH:0]     sum_add, sum_sub, mul_sum;
    logic [WIDTH-1:0]   sc_res, sh_next;
    logic               sc_s, sc_z, sc_c, sc_v, sh_out, accept, is_shift, is_mul;
    logic [2*WIDTH-1:0] mul_next;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign alu_out   = res_q;
    assign S = s_q;
    assign Z = z_q;
    assign C = c_q;
    assign V = v_q;
    assign is_shift  = (opcode == OP_SLL) | (opcode == OP_SRL) | (opcode == OP_SRA);
    assign is_mul    = (opcode == OP_MUL) & (MUL_EN != 0);

    // Single-cycle result and flags straight from the request inputs (shifts here cover d==0 only)
    always_comb begin
        sum_add = {1'b0, alu_in_a} + {1'b0, alu_in_b};
        sum_sub = {1'b0, alu_in_a} + {1'b0, ~alu_in_b} + {{WIDTH{1'b0}}, 1'b1};
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res = sum_add[WIDTH-1:0];
                sc_c   = sum_add[WIDTH];
                sc_v   = (alu_in_a[WIDTH-1] == alu_in_b[WIDTH-1]) & (sum_add[WIDTH-1] != alu_in_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                sc_res = (opcode == OP_CMP) ? alu_in_a : sum_sub[WIDTH-1:0];
                sc_c   = sum_sub[WIDTH];
                sc_v   = (alu_in_a[WIDTH-1] != alu_in_b[WIDTH-1]) & (sum_sub[WIDTH-1] != alu_in_a[WIDTH-1]);
            end
            OP_AND:                 sc_res = alu_in_a & alu_in_b;
            OP_OR:                  sc_res = alu_in_a | alu_in_b;
            OP_XOR:                 sc_res = alu_in_a ^ alu_in_b;
            OP_NOT:                 sc_res = ~alu_in_a;
            OP_MOVB:                sc_res = alu_in_b;
            OP_SLL, OP_SRL, OP_SRA: sc_res = alu_in_a;
            default:                sc_res = '0;
        endcase
        sc_s = sc_res[WIDTH-1];
        sc_z = (sc_res == '0);
        if (opcode == OP_CMP) begin
            sc_s = sum_sub[WIDTH-1];
            sc_z = (sum_sub[WIDTH-1:0] == '0);
        end
    end

    // One-bit shift step and one shift-add multiply step on the working registers
    always_comb begin
        sh_out  = a_q[0];
        sh_next = a_q >> 1;
        if (op_q == OP_SLL) begin
            sh_out  = a_q[WIDTH-1];
            sh_next = a_q << 1;
        end else if (op_q == OP_SRA) begin
            sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        end
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    // Next-state: iterate SHIFT/MUL, release DONE on out_ready, and start a new op on accept
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            SHIFT: begin
                a_d   = sh_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = sh_next;
                    s_d     = sh_next[WIDTH-1];
                    z_d     = (sh_next == '0);
                    c_d     = sh_out;
                    v_d     = 1'b0;
                end
            end
            MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = mul_next[WIDTH-1:0];
                    s_d     = mul_next[WIDTH-1];
                    z_d     = (mul_next[WIDTH-1:0] == '0);
                    c_d     = |mul_next[2*WIDTH-1:WIDTH];
                    v_d     = |mul_next[2*WIDTH-1:WIDTH];
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            op_d = opcode;
            if (is_shift && (d != '0)) begin
                state_d = SHIFT;
                a_d     = alu_in_a;
                cnt_d   = CW'(d);
            end else if (is_mul) begin
                state_d = MUL;
                a_d     = alu_in_a;
                prod_d  = {{WIDTH{1'b0}}, alu_in_b};
                cnt_d   = CW'(WIDTH);
            end else begin
                state_d = DONE;
                res_d   = sc_res;
                s_d     = sc_s;
                z_d     = sc_z;
                c_d     = sc_c;
                v_d     = sc_v;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed self-checking bench for exec_unit
module tb_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'd0;
    logic [3:0]  d = 4'd0;
    logic [15:0] alu_in_a = 16'd0;
    logic [15:0] alu_in_b = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_out;
    logic        S, Z, C, V, busy;

    int checks = 0;
    int errors = 0;

    exec_unit #(.WIDTH(16), .SHW(4), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .d(d), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .S(S), .Z(Z), .C(C), .V(V), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, scramble inputs after accept, measure latency, check result, consume it
    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh, input int exp_lat, input logic [15:0] exp_res,
                         input logic [3:0] exp_f);
        int lat;
        opcode = op; alu_in_a = a; alu_in_b = b; d = sh; in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        alu_in_a = 16'($urandom);
        alu_in_b = 16'($urandom);
        d        = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, {16'd0, alu_out}, {16'd0, exp_res});
        chk({tag, "_flags"}, {28'd0, S, Z, C, V}, {28'd0, exp_f});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drained"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_outs", {12'd0, alu_out, out_valid, busy, S, Z, C, V}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_idle", {30'd0, in_ready, busy}, 32'h2);

        // flags order in expectations: {S,Z,C,V}
        do_op("add_ovf",  4'd0,  16'h7FFF, 16'h0001, 4'd0,  1,  16'h8000, 4'b1001);
        do_op("add_carry",4'd0,  16'hFFFF, 16'h0001, 4'd0,  1,  16'h0000, 4'b0110);
        do_op("sub_neg",  4'd1,  16'h0003, 16'h0005, 4'd0,  1,  16'hFFFE, 4'b1000);
        do_op("sub_ovf",  4'd1,  16'h8000, 16'h0001, 4'd0,  1,  16'h7FFF, 4'b0011);
        do_op("cmp",      4'd11, 16'h0003, 16'h0005, 4'd0,  1,  16'h0003, 4'b1000);
        do_op("cmp_eq",   4'd11, 16'h1234, 16'h1234, 4'd0,  1,  16'h1234, 4'b0110);
        do_op("and",      4'd2,  16'hF0F0, 16'h3C3C, 4'd0,  1,  16'h3030, 4'b0000);
        do_op("not",      4'd5,  16'h00FF, 16'h0000, 4'd0,  1,  16'hFF00, 4'b1000);
        do_op("movb",     4'd6,  16'h1234, 16'h0000, 4'd0,  1,  16'h0000, 4'b0100);
        do_op("sra4",     4'd9,  16'h8001, 16'h0000, 4'd4,  5,  16'hF800, 4'b1000);
        do_op("sll0",     4'd7,  16'h8001, 16'h0000, 4'd0,  1,  16'h8001, 4'b1000);
        do_op("sll15",    4'd7,  16'h0003, 16'h0000, 4'd15, 16, 16'h8000, 4'b1010);
        do_op("srl15",    4'd8,  16'h8001, 16'h0000, 4'd15, 16, 16'h0001, 4'b0000);
        do_op("srl1",     4'd8,  16'h0003, 16'h0000, 4'd1,  2,  16'h0001, 4'b0010);
        do_op("mul_hi",   4'd10, 16'h0100, 16'h0100, 4'd0,  17, 16'h0000, 4'b0111);
        do_op("mul_small",4'd10, 16'h0003, 16'h0005, 4'd0,  17, 16'h000F, 4'b0000);
        do_op("rsvd",     4'd13, 16'h0005, 16'h0005, 4'd0,  1,  16'h0000, 4'b0100);

        // hold result while consumer stalls, then back-to-back accept on release
        opcode = 4'd0; alu_in_a = 16'h7FFF; alu_in_b = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_in_a = 16'($urandom);
            in_valid = (i == 1);
            @(negedge clk);
            chk("hold_outs", {12'd0, alu_out, out_valid, S, Z, C}, {12'd0, 16'h8000, 4'b1100});
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        opcode = 4'd4; alu_in_a = 16'hF0F0; alu_in_b = 16'h0FF0; in_valid = 1'b1;
        #1;
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_res", {11'd0, alu_out, out_valid, S, Z, C, V}, {11'd0, 16'hFF00, 5'b11000});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset in the middle of a multiply
        opcode = 4'd10; alu_in_a = 16'h0003; alu_in_b = 16'h0005; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mul_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst", {13'd0, alu_out, out_valid, busy, S}, {13'd0, 16'hFF00, 3'b000} & 32'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("midrst_noresult", seen, 0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
